sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Multi-cycle N-bit two's-complement subtractor: D = X - Y.
- Processes K bits per clock, least-significant chunk first, with one borrow flip-flop between chunks.
- Start/Busy/Done handshake.
- Area-reduced counterpart to the parallel n-bit adders in the arithmetic datapath. Feeds comparators and ALU paths that accept multi-cycle latency.

Parameters:
N, 16, operand/result width in bits; must be a multiple of K.
K, 4, chunk width processed per cycle; 1 <= K <= N.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only in IDLE or DONE.
X  input  N  minuend; captured on accepted Start.
Y  input  N  subtrahend; captured on accepted Start.
Busy  output  1  high while chunks are being processed.
Done  output  1  one-cycle pulse when the result becomes valid.
D  output  N  difference; valid from Done, held until next accepted Start.
Borrow  output  1  unsigned borrow-out (1 when X < Y unsigned).
Overflow  output  1  signed overflow flag.

Behaviour:
- One clock (Clock). Reset is synchronous and active-high (Reset). No asynchronous reset.
- Reset values: state = IDLE, Busy = 0, Done = 0, D = 0, Borrow = 0, Overflow = 0, chunk counter = 0, borrow FF = 0.
- States:
  - IDLE: Busy = 0, Done = 0.
  - RUN: Busy = 1.
  - DONE: Done = 1 for exactly one cycle.
- IDLE or DONE with Start = 1 at edge t:
  - latch X into an operand shift register and Y into another;
  - clear the counter; set the internal carry FF = 1 (subtraction as X + ~Y + 1);
  - go to RUN.
- RUN, each cycle:
  - slice computes {c, s} = Xk + ~Yk + carry on the low K bits;
  - s shifts into the MSB end of the result register; operands shift right by K;
  - carry FF <= c; counter increments.
- After N/K RUN cycles, go to DONE. Busy is high for cycles t+1 .. t+N/K, and Done is high in cycle t+N/K+1.
- In DONE:
  - D = assembled result;
  - Borrow = ~final carry;
  - Overflow = (X[N-1] != Y[N-1]) && (D[N-1] != X[N-1]), using latched operand signs.
- DONE -> IDLE next cycle, unless Start = 1, which is accepted back-to-back (DONE -> RUN).
- D/Borrow/Overflow hold their values through IDLE until updated at the next DONE. They do not change during RUN; the result assembles in an internal register.
- Start while in RUN is ignored; X/Y changes during RUN have no effect.
- Reset asserted mid-RUN: next cycle equals the reset state and the partial result is discarded. Reset has priority over Start.
- K == N: single RUN cycle; latency from accepted Start to Done = 2 cycles.

Optional Feature:
- Macro: SUB_SERIAL_SATURATE_EN.
- Defined: when Overflow = 1, D is clamped.
  - X non-negative: D = 2^(N-1) - 1 (0x7FFF for N=16).
  - X negative: D = -2^(N-1) (0x8000).
  - Overflow and Borrow still report the unclamped arithmetic.
- Undefined: D is the wrapped modulo-2^N difference.
- Timing is identical either way; clamping is applied when entering DONE.

Decomposition:
- Shared package sub_serial_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding;
  - function computing counter width as clog2(N/K);
  - localparam for chunk count N/K.
- One natural sub-module, sub_chunk: combinational K-bit slice.
  - Inputs a[K], b[K], cin.
  - Outputs s[K] = a + ~b + cin, cout.
  - Instantiated once in sub_serial; carry registered in the parent.

Test Plan (N=16, K=4 unless stated):
1. Reset, then Start with X = 0x1234, Y = 0x0034 -> Busy high 4 cycles; Done pulse at cycle 5; D = 0x1200, Borrow = 0, Overflow = 0.
2. X = 0x0000, Y = 0x0001 -> D = 0xFFFF, Borrow = 1, Overflow = 0.
3. X = 0x8000, Y = 0x0001 -> Borrow = 0, Overflow = 1. D = 0x7FFF without the macro; D = 0x8000 with SUB_SERIAL_SATURATE_EN.
4. X = 0x7FFF, Y = 0xFFFF -> Borrow = 1, Overflow = 1. D = 0x8000 without the macro; D = 0x7FFF with it.
5. Start pulse with X = 0x0005, Y = 0x0003, then Start = 1 again in RUN with X = 0xFFFF -> second request ignored; D = 0x0002. Start held high in DONE -> back-to-back run accepted, Busy reasserts the next cycle.
6. Reset asserted in the 2nd RUN cycle of X = 0x1111, Y = 0x0001 -> next cycle Busy = 0, Done = 0, D = 0x0000; no Done pulse follows. Repeat with K = 16: latency 2 cycles, same results as test 1.

Source files
------------

// File: rtl/sub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial_pkg
// Purpose  : Shared types and helpers for the chunk-serial subtractor.
// Revision : 1.0  initial release
// ============================================================================
package sub_serial_pkg;

    // Controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry and the chunk count it implies.
    localparam int DEFAULT_N      = 16;
    localparam int DEFAULT_K      = 4;
    localparam int DEFAULT_CHUNKS = DEFAULT_N / DEFAULT_K;

    // Chunk-counter width: clog2(N/K), never narrower than one bit so the
    // single-chunk (K == N) build still has a legal counter.
    function automatic int cnt_width(input int n, input int k);
        int w;
        w = $clog2(n / k);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk
// Purpose  : Combinational K-bit subtract slice: {cout, s} = a + ~b + cin.
// Revision : 1.0  initial release
// ============================================================================
module sub_chunk #(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout
);

    logic [K:0] w_sum;

    // Widen every term to K+1 bits so the carry lands in the top bit.
    assign w_sum = {1'b0, a} + {1'b0, ~b} + {{K{1'b0}}, cin};
    assign s     = w_sum[K-1:0];
    assign cout  = w_sum[K];

endmodule
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Purpose  : Multi-cycle N-bit two's-complement subtractor D = X - Y,
//            K bits per clock, LSB chunk first, Start/Busy/Done handshake.
// Options  : SUB_SERIAL_SATURATE_EN - clamp D to the signed range on overflow.
// Revision : 1.0  initial release
// ============================================================================
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int K = DEFAULT_K
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] D,
    output logic         Borrow,
    output logic         Overflow
);

    localparam int CHUNKS = N / K;
    localparam int CW     = cnt_width(N, K);
    localparam logic [CW-1:0] c_LAST = CW'(CHUNKS - 1);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;

    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic            r_xs;
    logic            r_ys;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;

    logic [K-1:0]    w_s;
    logic            w_c;
    logic [N-1:0]    w_full;
    logic [N-1:0]    w_dval;
    logic            w_ovf;

    assign w_last = (r_cnt == c_LAST);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; Start only counts in IDLE or DONE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    sub_chunk #(
        .K (K)
    ) u_chunk (
        .a    (r_x[K-1:0]),
        .b    (r_y[K-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // The result assembles MSB-first; only the upper N-K bits need storage
    // because the current slice output supplies the top chunk directly.
    generate
        if (K == N) begin : g_single
            assign w_full = w_s;
        end else begin : g_multi
            logic [N-K-1:0] r_acc;

            // Partial-result shift register, filled from the top.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_full[N-1:K];
                end
            end

            assign w_full = {w_s, r_acc};
        end
    endgenerate

    // Signed overflow from the latched operand signs and the raw result sign.
    assign w_ovf = (r_xs != r_ys) && (w_full[N-1] != r_xs);

`ifdef SUB_SERIAL_SATURATE_EN
    assign w_dval = w_ovf ? (r_xs ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                          : w_full;
`else
    assign w_dval = w_full;
`endif

    // Operand capture, chunk stepping, and result publication on the last chunk.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_xs     <= 1'b0;
            r_ys     <= 1'b0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            D        <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
        end else if (w_accept) begin
            r_x     <= X;
            r_y     <= Y;
            r_xs    <= X[N-1];
            r_ys    <= Y[N-1];
            r_cnt   <= '0;
            r_carry <= 1'b1;
        end else if (r_state == RUN) begin
            r_x     <= r_x >> K;
            r_y     <= r_y >> K;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                D        <= w_dval;
                Borrow   <= ~w_c;
                Overflow <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_serial
// Purpose  : Directed self-checking bench for sub_serial (N=16, K=4 and K=16).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sub_serial;

`ifdef SUB_SERIAL_SATURATE_EN
    localparam logic [15:0] EXP3 = 16'h8000;
    localparam logic [15:0] EXP4 = 16'h7FFF;
`else
    localparam logic [15:0] EXP3 = 16'h7FFF;
    localparam logic [15:0] EXP4 = 16'h8000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [15:0] x, y, x2, y2;
    logic        busy, done, borrow, ovf;
    logic        busy2, done2, borrow2, ovf2;
    logic [15:0] d, d2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sub_serial #(.N(16), .K(4)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .X(x), .Y(y),
        .Busy(busy), .Done(done), .D(d), .Borrow(borrow), .Overflow(ovf)
    );

    sub_serial #(.N(16), .K(16)) dut_full (
        .Clock(clk), .Reset(rst), .Start(start2), .X(x2), .Y(y2),
        .Busy(busy2), .Done(done2), .D(d2), .Borrow(borrow2), .Overflow(ovf2)
    );

    // Issue one request and wait (bounded) for Done; reports latency and Busy cycles.
    task automatic do_op(input logic [15:0] xa, input logic [15:0] ya,
                         output int lat, output int nbusy);
        x = xa; y = ya; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        x = 16'h0; y = 16'h0; x2 = 16'h0; y2 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (d !== 16'h0000) $display("FAIL reset_d: got %h want 0000", d); else pass_cnt++;
        total_cnt++; if ({borrow, ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {borrow, ovf}); else pass_cnt++;
        total_cnt++; if ({busy2, done2, borrow2, ovf2} !== 4'b0000) $display("FAIL reset_full_ctl: got %b want 0000", {busy2, done2, borrow2, ovf2}); else pass_cnt++;
        total_cnt++; if (d2 !== 16'h0000) $display("FAIL reset_full_d: got %h want 0000", d2); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, nb;
        do_op(16'h1234, 16'h0034, lat, nb);
        total_cnt++; if (lat !== 5) $display("FAIL basic_latency: got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (nb !== 4) $display("FAIL basic_busy_cycles: got %0d want 4", nb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (d !== 16'h1200) $display("FAIL basic_d: got %h want 1200", d); else pass_cnt++;
        total_cnt++; if ({borrow, ovf} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {borrow, ovf}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (d !== 16'h1200) $display("FAIL basic_d_hold: got %h want 1200", d); else pass_cnt++;
    endtask

    task automatic test_borrow;
        int lat, nb;
        do_op(16'h0000, 16'h0001, lat, nb);
        total_cnt++; if (d !== 16'hFFFF) $display("FAIL borrow_d: got %h want ffff", d); else pass_cnt++;
        total_cnt++; if ({borrow, ovf} !== 2'b10) $display("FAIL borrow_flags: got %b want 10", {borrow, ovf}); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int lat, nb;
        do_op(16'h8000, 16'h0001, lat, nb);
        total_cnt++; if (d !== EXP3) $display("FAIL ovf_neg_d: got %h want %h", d, EXP3); else pass_cnt++;
        total_cnt++; if ({borrow, ovf} !== 2'b01) $display("FAIL ovf_neg_flags: got %b want 01", {borrow, ovf}); else pass_cnt++;
        @(posedge clk); #1;
        do_op(16'h7FFF, 16'hFFFF, lat, nb);
        total_cnt++; if (d !== EXP4) $display("FAIL ovf_pos_d: got %h want %h", d, EXP4); else pass_cnt++;
        total_cnt++; if ({borrow, ovf} !== 2'b11) $display("FAIL ovf_pos_flags: got %b want 11", {borrow, ovf}); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        x = 16'h0005; y = 16'h0003; start = 1'b1;
        @(posedge clk); #1;              // RUN cycle 1
        start = 1'b0; lat = 1;
        @(posedge clk); #1; lat++;       // RUN cycle 2: request arrives while busy
        start = 1'b1; x = 16'hFFFF;
        @(posedge clk); #1; lat++;
        start = 1'b0; x = 16'h0000;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total_cnt++; if (lat !== 5) $display("FAIL b2b_ignored_latency: got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (d !== 16'h0002) $display("FAIL b2b_ignored_d: got %h want 0002", d); else pass_cnt++;
        // Start held in DONE: accepted immediately.
        start = 1'b1; x = 16'h0010; y = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL b2b_rerun: got busy/done %b want 10", {busy, done}); else pass_cnt++;
        total_cnt++; if (d !== 16'h0002) $display("FAIL b2b_d_stable_in_run: got %h want 0002", d); else pass_cnt++;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total_cnt++; if (lat !== 5) $display("FAIL b2b_second_latency: got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (d !== 16'h000F) $display("FAIL b2b_second_d: got %h want 000f", d); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        x = 16'h1111; y = 16'h0001; start = 1'b1;
        @(posedge clk); #1;              // RUN cycle 1
        start = 1'b0;
        @(posedge clk); #1;              // RUN cycle 2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL midrst_ctl: got busy/done %b want 00", {busy, done}); else pass_cnt++;
        total_cnt++; if (d !== 16'h0000) $display("FAIL midrst_d: got %h want 0000", d); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL midrst_no_done: got activity %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_full_width;
        x2 = 16'h1234; y2 = 16'h0034; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        total_cnt++; if ({busy2, done2} !== 2'b10) $display("FAIL full_run: got busy/done %b want 10", {busy2, done2}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if ({busy2, done2} !== 2'b01) $display("FAIL full_done: got busy/done %b want 01", {busy2, done2}); else pass_cnt++;
        total_cnt++; if (d2 !== 16'h1200) $display("FAIL full_d: got %h want 1200", d2); else pass_cnt++;
        total_cnt++; if ({borrow2, ovf2} !== 2'b00) $display("FAIL full_flags: got %b want 00", {borrow2, ovf2}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (done2 !== 1'b0) $display("FAIL full_done_pulse: got %b want 0", done2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_full_width();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
`default_nettype wire
